skolem_sweep_ctrl: RTL and testbench
====================================

// Module: skolem_sweep_ctrl
// PURPOSE
//   Sequential driver and collector placed around one combinational spec
//   evaluator (a CNF block with universal inputs and one existential output).
//   On start, it sweeps every universal-input assignment and drives candidate
//   y values into the evaluator. It samples the evaluator's result, builds the
//   Skolem truth table for y, and reports realizability plus the failing
//   assignments. Upstream of the evaluator: it feeds eval_x/eval_y and
//   consumes eval_ok (the evaluator's o_1).
// PARAMETERS
//   N_IN   3   number of universal inputs; sweep length is 2**N_IN (1..8 supported)
// PORTS
//   clk          in   1            single clock, rising edge
//   rst_n        in   1            asynchronous, active-low reset
//   start        in   1            request a sweep; honoured only in IDLE
//   eval_ok      in   1            evaluator result for current eval_x/eval_y (combinational)
//   eval_x       out  N_IN         universal assignment under test; bit0=v_1, bit1=v_3, bit2=v_4 for N_IN=3
//   eval_y       out  1            candidate existential value (v_2)
//   busy         out  1            high from the cycle after start is accepted until DONE exits
//   done         out  1            one-cycle pulse; the result outputs are valid from this cycle on
//   realizable   out  1            1 if every assignment had a satisfying y
//   skolem_tt    out  2**N_IN      bit i = chosen y for eval_x==i (0 where no y works)
//   fail_count   out  N_IN+1       number of assignments with no satisfying y
//   first_fail_x out  N_IN         lowest failing index; meaningful only if fail_count!=0
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; all outputs 0. Reset during a sweep
//     discards the partial results; no done pulse is produced.
//   - FSM: IDLE, TRY0, TRY1, DONE.
//     IDLE: start=1 at an edge -> TRY0, idx<=0, clear skolem_tt/fail_count/first_fail_x/realizable.
//     TRY0: eval_x=idx, eval_y=0. At the edge, eval_ok=1 -> write tt[idx]=0 and advance; else -> TRY1.
//     TRY1: eval_x=idx, eval_y=1. At the edge, eval_ok=1 -> write tt[idx]=1; else write tt[idx]=0,
//           fail_count+=1, and record first_fail_x if this is the first failure. Then advance.
//     Advance: idx==2**N_IN-1 -> DONE; else idx+=1 -> TRY0.
//     DONE: done=1 and busy=1 for exactly one cycle; realizable=(fail_count==0) is registered
//           on entry to DONE. The next state is IDLE.
//   - The evaluator is combinational: eval_ok is sampled at the same edge that
//     ends the cycle in which eval_x/eval_y are driven. eval_x/eval_y are
//     registered outputs and are glitch-free for the whole cycle.
//   - y=0 is always tried first (a deterministic, minimal Skolem choice).
//   - Latency: the sweep takes 2**N_IN to 2*2**N_IN TRY cycles, then 1 DONE cycle.
//   - start while busy is ignored. start held high in IDLE begins one sweep.
//     A new sweep can begin the cycle after DONE.
//   - Results hold their values in IDLE until the next accepted start.
//     eval_x/eval_y return to 0 in IDLE and DONE.
//   - fail_count saturates naturally: the maximum is 2**N_IN and fits in N_IN+1 bits.
// TESTING
//   1 eval_ok tied 1, start pulse -> 8 TRY0 cycles, done on cycle 9 after acceptance,
//     realizable=1, skolem_tt=8'h00, fail_count=0.
//   2 eval_ok tied 0 -> 16 TRY cycles, realizable=0, fail_count=8, first_fail_x=0, skolem_tt=8'h00.
//   3 eval_ok=eval_y -> every index visits TRY0 then TRY1 (16 cycles), skolem_tt=8'hFF, realizable=1.
//   4 ex7 CNF evaluator attached (clauses v2|v3|~v4, ~v2|~v3, ~v2|v4, v1|v2, ~v1|~v2)
//     -> 13 TRY cycles, skolem_tt=8'h10, fail_count=4 (idx 0,2,5,6), first_fail_x=0, realizable=0.
//   5 rst_n pulsed low at TRY cycle 5 of test 4 -> all outputs 0 immediately, no done pulse;
//     a following start reproduces the full test 4 result.
//   6 start re-asserted while busy, then start held high through DONE -> the first sweep is
//     unaffected; a second sweep begins in the cycle after DONE.

Source files
------------

// File: rtl/skolem_sweep_ctrl.sv
// Sweeps every universal-input assignment through an external combinational
// evaluator, picks the lowest satisfying y for each, and reports the Skolem table.
module skolem_sweep_ctrl #(
   parameter int N_IN = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 eval_ok,
   output logic [N_IN-1:0]      eval_x,
   output logic                 eval_y,
   output logic                 busy,
   output logic                 done,
   output logic                 realizable,
   output logic [2**N_IN-1:0]   skolem_tt,
   output logic [N_IN:0]        fail_count,
   output logic [N_IN-1:0]      first_fail_x
);

   localparam int unsigned      N_X      = 2**N_IN;
   localparam logic [N_IN-1:0]  LAST_IDX = N_IN'(N_X - 1);

   typedef enum logic [1:0] {IDLE, TRY0, TRY1, DONE} state_t;

   state_t              r_state;
   logic [N_IN-1:0]     r_idx;
   logic [N_IN-1:0]     r_eval_x;
   logic                r_eval_y;
   logic                r_busy;
   logic                r_done;
   logic                r_realizable;
   logic [N_X-1:0]      r_tt;
   logic [N_IN:0]       r_fail_count;
   logic [N_IN-1:0]     r_first_fail;

   logic                w_last;
   logic                w_fail_now;
   logic [N_IN:0]       w_fail_next;
   logic [N_IN-1:0]     w_idx_inc;

   assign w_last      = (r_idx == LAST_IDX);
   assign w_fail_now  = (r_state == TRY1) && !eval_ok;
   assign w_fail_next = r_fail_count + {{N_IN{1'b0}}, w_fail_now};
   assign w_idx_inc   = r_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_eval_x     <= '0;
         r_eval_y     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_realizable <= 1'b0;
         r_tt         <= '0;
         r_fail_count <= '0;
         r_first_fail <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state      <= TRY0;
                  r_idx        <= '0;
                  r_eval_x     <= '0;
                  r_eval_y     <= 1'b0;
                  r_busy       <= 1'b1;
                  r_realizable <= 1'b0;
                  r_tt         <= '0;
                  r_fail_count <= '0;
                  r_first_fail <= '0;
               end
            end
            TRY0, TRY1: begin
               if (r_state == TRY0 && !eval_ok) begin
                  r_state  <= TRY1;
                  r_eval_y <= 1'b1;
               end else begin
                  // y=0 wins whenever it works; a double failure leaves a 0 entry
                  r_tt[r_idx] <= (r_state == TRY1) && eval_ok;
                  if (w_fail_now) begin
                     r_fail_count <= w_fail_next;
                     if (r_fail_count == '0)
                        r_first_fail <= r_idx;
                  end
                  if (w_last) begin
                     r_state      <= DONE;
                     r_done       <= 1'b1;
                     r_realizable <= (w_fail_next == '0);
                     r_eval_x     <= '0;
                     r_eval_y     <= 1'b0;
                  end else begin
                     r_state  <= TRY0;
                     r_idx    <= w_idx_inc;
                     r_eval_x <= w_idx_inc;
                     r_eval_y <= 1'b0;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign eval_x       = r_eval_x;
   assign eval_y       = r_eval_y;
   assign busy         = r_busy;
   assign done         = r_done;
   assign realizable   = r_realizable;
   assign skolem_tt    = r_tt;
   assign fail_count   = r_fail_count;
   assign first_fail_x = r_first_fail;

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// Directed bench for skolem_sweep_ctrl: a table of evaluator behaviours with
// hand-computed sweep results, plus reset-mid-sweep and start-while-busy sequences.
module tb_skolem_sweep_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        eval_ok;
   logic [2:0]  eval_x;
   logic        eval_y;
   logic        busy;
   logic        done;
   logic        realizable;
   logic [7:0]  skolem_tt;
   logic [3:0]  fail_count;
   logic [2:0]  first_fail_x;

   int          mode;
   int          n_cmp;
   int          n_err;

   typedef struct {
      int         mode;
      int         exp_try;
      logic [7:0] exp_tt;
      logic [3:0] exp_fail;
      logic [2:0] exp_ffx;
      logic       exp_real;
   } vec_t;

   vec_t vecs[6];

   skolem_sweep_ctrl #(.N_IN(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .eval_ok      (eval_ok),
      .eval_x       (eval_x),
      .eval_y       (eval_y),
      .busy         (busy),
      .done         (done),
      .realizable   (realizable),
      .skolem_tt    (skolem_tt),
      .fail_count   (fail_count),
      .first_fail_x (first_fail_x)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Evaluator models: 0 tied 1, 1 tied 0, 2 ok=y, 3 ex7 CNF, 4 fail at x=3,6, 5 ok=(y==x[0])
   function automatic logic eval_f(input int m, input logic [2:0] x, input logic y);
      logic v1, v3, v4;
      v1 = x[0];
      v3 = x[1];
      v4 = x[2];
      case (m)
         0: return 1'b1;
         1: return 1'b0;
         2: return y;
         3: return (y | v3 | ~v4) & (~y | ~v3) & (~y | v4) & (v1 | y) & (~v1 | ~y);
         4: return !(x == 3'd3 || x == 3'd6);
         default: return (y == x[0]);
      endcase
   endfunction

   assign eval_ok = eval_f(mode, eval_x, eval_y);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_sweep(input vec_t v, input string tag);
      int         cyc;
      int         trace_bad;
      logic [2:0] ex;
      logic       ey;
      mode = v.mode;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 0;
      trace_bad = 0;
      ex = 3'd0;
      ey = 1'b0;
      while (!done && cyc < 40) begin
         if (!busy || eval_x !== ex || eval_y !== ey) trace_bad++;
         if (ey == 1'b0 && eval_f(v.mode, ex, 1'b0)) ex = ex + 3'd1;
         else if (ey == 1'b0) ey = 1'b1;
         else begin
            ey = 1'b0;
            ex = ex + 3'd1;
         end
         cyc++;
         @(negedge clk);
      end
      check({tag, ".done_seen"}, {31'd0, done}, 32'd1);
      check({tag, ".try_cycles"}, cyc, v.exp_try);
      check({tag, ".trace"}, trace_bad, 32'd0);
      check({tag, ".busy_in_done"}, {31'd0, busy}, 32'd1);
      check({tag, ".skolem_tt"}, {24'd0, skolem_tt}, {24'd0, v.exp_tt});
      check({tag, ".fail_count"}, {28'd0, fail_count}, {28'd0, v.exp_fail});
      check({tag, ".first_fail_x"}, {29'd0, first_fail_x}, {29'd0, v.exp_ffx});
      check({tag, ".realizable"}, {31'd0, realizable}, {31'd0, v.exp_real});
      $display("sweep %s mode=%0d tries=%0d tt=%02h fails=%0d ffx=%0d real=%0d",
               tag, v.mode, cyc, skolem_tt, fail_count, first_fail_x, realizable);
      @(negedge clk);
      check({tag, ".idle_flags"}, {28'd0, done, busy, eval_y, 1'b0}, 32'd0);
      check({tag, ".idle_eval_x"}, {29'd0, eval_x}, 32'd0);
      check({tag, ".hold_tt"}, {24'd0, skolem_tt}, {24'd0, v.exp_tt});
      check({tag, ".hold_real"}, {31'd0, realizable}, {31'd0, v.exp_real});
   endtask

   initial begin
      int cyc;
      int done_seen;
      n_cmp = 0;
      n_err = 0;
      mode  = 0;
      start = 1'b0;
      rst_n = 1'b0;

      //                mode try  tt     fail  ffx   real
      vecs[0] = '{0,   8, 8'h00, 4'd0, 3'd0, 1'b1};
      vecs[1] = '{1,  16, 8'h00, 4'd8, 3'd0, 1'b0};
      vecs[2] = '{2,  16, 8'hFF, 4'd0, 3'd0, 1'b1};
      vecs[3] = '{3,  13, 8'h10, 4'd4, 3'd0, 1'b0};
      vecs[4] = '{4,  10, 8'h00, 4'd2, 3'd3, 1'b0};
      vecs[5] = '{5,  12, 8'hAA, 4'd0, 3'd0, 1'b1};

      #2;
      check("reset_outputs",
            {10'd0, eval_x, eval_y, busy, done, realizable, skolem_tt, fail_count, first_fail_x},
            32'd0);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("idle_no_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 6; i++) begin
         run_sweep(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the fifth TRY cycle of the ex7 sweep
      mode = 3;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_outputs",
            {10'd0, eval_x, eval_y, busy, done, realizable, skolem_tt, fail_count, first_fail_x},
            32'd0);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      done_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check("midreset_no_done", done_seen, 32'd0);
      $display("sweep midreset mode=3 outputs cleared, idle cycles without done=20");
      run_sweep(vecs[3], "after_reset");

      // start re-asserted while busy and held high through DONE
      mode = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 0;
      repeat (2) begin
         @(negedge clk);
         cyc++;
      end
      start = 1'b1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("busystart.first_try", cyc, 32'd8);
      check("busystart.first_done", {31'd0, done}, 32'd1);
      check("busystart.first_real", {31'd0, realizable}, 32'd1);
      check("busystart.first_tt", {24'd0, skolem_tt}, 32'd0);
      @(negedge clk);
      check("busystart.idle_gap", {30'd0, busy, done}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      check("busystart.second_busy", {31'd0, busy}, 32'd1);
      check("busystart.second_x", {29'd0, eval_x}, 32'd0);
      cyc = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("busystart.second_try", cyc, 32'd8);
      check("busystart.second_done", {31'd0, done}, 32'd1);
      $display("sweep busystart mode=0 second sweep tries=%0d real=%0d", cyc, realizable);
      @(negedge clk);
      check("busystart.end_idle", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
